// File: rtl/typed_ndata_to_axi_pkg.sv
// Shared types for the typed-ndata to AXI-stream egress adapter.
//   data8_t     : one byte element of a typed ndata beat
//   type_t      : per-packet element type tag (mirrors the libstf type set)
//   pkt_state_e : packet framing state (type of current packet sent or not)
package typed_ndata_to_axi_pkg;

  typedef logic [7:0] data8_t;

  typedef enum logic [3:0] {
    TYPE_T0 = 4'd0,
    TYPE_T1 = 4'd1,
    TYPE_T2 = 4'd2,
    TYPE_T3 = 4'd3
  } type_t;

  typedef enum logic {
    FIRST = 1'b0,
    BODY  = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/axis_output_reg.sv
// Single-stage ready-chained AXI-stream output register.
// Loads a new beat whenever the slot is free (empty or being drained),
// clears tvalid when free and nothing is offered, otherwise holds all fields.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   load_i                : a beat is offered and accepted this cycle
//   tdata_i/tkeep_i/tlast_i : beat contents to load
//   tready_i              : downstream ready
//   tdata_o/tkeep_o/tlast_o/tvalid_o : registered AXI-stream outputs
//   can_load_o            : slot is free this cycle
module axis_output_reg #(
  parameter int unsigned AXI_WIDTH = 512
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [AXI_WIDTH-1:0]   tdata_i,
  input  logic [AXI_WIDTH/8-1:0] tkeep_i,
  input  logic                   tlast_i,
  input  logic                   tready_i,
  output logic [AXI_WIDTH-1:0]   tdata_o,
  output logic [AXI_WIDTH/8-1:0] tkeep_o,
  output logic                   tlast_o,
  output logic                   tvalid_o,
  output logic                   can_load_o
);

  logic [AXI_WIDTH-1:0]   tdata_q;
  logic [AXI_WIDTH/8-1:0] tkeep_q;
  logic                   tlast_q;
  logic                   tvalid_q;

  assign can_load_o = !tvalid_q || tready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
    end else if (can_load_o) begin
      tvalid_q <= load_i;
    end
  end

  // Payload needs no reset: it is only observed while tvalid is set.
  always_ff @(posedge clk) begin
    if (can_load_o && load_i) begin
      tdata_q <= tdata_i;
      tkeep_q <= tkeep_i;
      tlast_q <= tlast_i;
    end
  end

  assign tdata_o  = tdata_q;
  assign tkeep_o  = tkeep_q;
  assign tlast_o  = tlast_q;
  assign tvalid_o = tvalid_q;

endmodule

// File: rtl/typed_ndata_to_axi.sv
// Typed ndata -> AXI-stream egress adapter.
// Forwards byte beats to an AXI stream through one output register and emits
// the packet type once per packet on a separate ready/valid stream, never
// letting the first beat of a packet pass ahead of its type handshake.
// Optional macro TYPED_NDATA_TO_AXI_TYPE_CHECK_EN adds a sticky type_err_o
// flag raised when a body beat's type differs from the packet's latched type.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_*                       : typed ndata input (data/keep/last/valid/typ, ready)
//   out_type_*                 : per-packet type descriptor (data/valid, ready)
//   out_t*                     : AXI-stream output (tdata/tkeep/tlast/tvalid, tready)
//   type_err_o                 : sticky type mismatch (only with the macro)
module typed_ndata_to_axi
  import typed_ndata_to_axi_pkg::*;
#(
  parameter int unsigned DATABEAT_SIZE = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  data8_t [DATABEAT_SIZE-1:0]       in_data_i,
  input  logic   [DATABEAT_SIZE-1:0]       in_keep_i,
  input  logic                             in_last_i,
  input  logic                             in_valid_i,
  input  type_t                            in_typ_i,
  output logic                             in_ready_o,
  output type_t                            out_type_data_o,
  output logic                             out_type_valid_o,
  input  logic                             out_type_ready_i,
`ifdef TYPED_NDATA_TO_AXI_TYPE_CHECK_EN
  output logic                             type_err_o,
`endif
  output logic   [DATABEAT_SIZE*8-1:0]     out_tdata_o,
  output logic   [DATABEAT_SIZE-1:0]       out_tkeep_o,
  output logic                             out_tlast_o,
  output logic                             out_tvalid_o,
  input  logic                             out_tready_i
);

  localparam int unsigned AXI_WIDTH = DATABEAT_SIZE * 8;

  pkt_state_e state_q, state_d;
  logic       can_load;
  logic       accept;
  logic       type_hs;
  logic [AXI_WIDTH-1:0] beat_tdata;

  // Packed byte array already places data[I] at bits [8*I +: 8].
  assign beat_tdata = in_data_i;

  assign out_type_valid_o = in_valid_i && (state_q == FIRST);
  assign out_type_data_o  = in_typ_i;
  assign type_hs          = out_type_valid_o && out_type_ready_i;
  assign in_ready_o       = can_load && ((state_q == BODY) || out_type_ready_i);
  assign accept           = in_valid_i && in_ready_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // In FIRST, a type handshake without a beat accept (output stalled) still
  // moves to BODY so the type is not emitted twice for the held beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FIRST: begin
        if (accept) begin
          state_d = in_last_i ? FIRST : BODY;
        end else if (type_hs) begin
          state_d = BODY;
        end
      end
      BODY: begin
        if (accept && in_last_i) begin
          state_d = FIRST;
        end
      end
      default: state_d = FIRST;
    endcase
  end

`ifdef TYPED_NDATA_TO_AXI_TYPE_CHECK_EN
  type_t typ_q;
  logic  type_err_q;

  always_ff @(posedge clk) begin
    if (type_hs) begin
      typ_q <= in_typ_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      type_err_q <= 1'b0;
    end else if (accept && (state_q == BODY) && (in_typ_i != typ_q)) begin
      type_err_q <= 1'b1;
    end
  end

  assign type_err_o = type_err_q;
`endif

  axis_output_reg #(
    .AXI_WIDTH(AXI_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .tdata_i    (beat_tdata),
    .tkeep_i    (in_keep_i),
    .tlast_i    (in_last_i),
    .tready_i   (out_tready_i),
    .tdata_o    (out_tdata_o),
    .tkeep_o    (out_tkeep_o),
    .tlast_o    (out_tlast_o),
    .tvalid_o   (out_tvalid_o),
    .can_load_o (can_load)
  );

endmodule

// File: tb/tb_typed_ndata_to_axi.sv
module tb_typed_ndata_to_axi;
  import typed_ndata_to_axi_pkg::*;

  localparam int unsigned DBS = 8;
  localparam int unsigned AW  = DBS * 8;

  logic                 clk;
  logic                 rst_n;
  data8_t [DBS-1:0]     in_data;
  logic   [DBS-1:0]     in_keep;
  logic                 in_last;
  logic                 in_valid;
  type_t                in_typ;
  logic                 in_ready;
  type_t                otd;
  logic                 otv;
  logic                 otr;
  logic   [AW-1:0]      tdata;
  logic   [DBS-1:0]     tkeep;
  logic                 tlast;
  logic                 tvalid;
  logic                 tready;
`ifdef TYPED_NDATA_TO_AXI_TYPE_CHECK_EN
  logic                 type_err;
`endif

  typed_ndata_to_axi #(
    .DATABEAT_SIZE(DBS)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_data_i        (in_data),
    .in_keep_i        (in_keep),
    .in_last_i        (in_last),
    .in_valid_i       (in_valid),
    .in_typ_i         (in_typ),
    .in_ready_o       (in_ready),
    .out_type_data_o  (otd),
    .out_type_valid_o (otv),
    .out_type_ready_i (otr),
`ifdef TYPED_NDATA_TO_AXI_TYPE_CHECK_EN
    .type_err_o       (type_err),
`endif
    .out_tdata_o      (tdata),
    .out_tkeep_o      (tkeep),
    .out_tlast_o      (tlast),
    .out_tvalid_o     (tvalid),
    .out_tready_i     (tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected tdata for a beat whose byte I holds base+I.
  function automatic logic [63:0] pat(input int unsigned base);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < DBS; i++) r[8*i +: 8] = 8'(base + i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input int unsigned base, input logic [DBS-1:0] k,
                       input logic l, input type_t t);
    in_valid = v;
    for (int unsigned i = 0; i < DBS; i++) in_data[i] = 8'(base + i);
    in_keep  = k;
    in_last  = l;
    in_typ   = t;
  endtask

  task automatic idle();
    drive(1'b0, 0, '0, 1'b0, TYPE_T0);
  endtask

  initial begin
    type_t ty [3];
    int b, recv, nth, cyc;
    logic stalled;
    logic [63:0] held;

    ty[0] = TYPE_T0; ty[1] = TYPE_T1; ty[2] = TYPE_T2;

    // Reset and idle
    rst_n = 1'b0; otr = 1'b1; tready = 1'b1;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); mid();
      chk("idle_tvalid", 64'(tvalid), 64'd0);
      chk("idle_otv", 64'(otv), 64'd0);
`ifdef TYPED_NDATA_TO_AXI_TYPE_CHECK_EN
      chk("idle_err", 64'(type_err), 64'd0);
`endif
    end

    // 4-beat packet, type T0, sinks ready
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      drive(1'b1, 16*k, 8'hFF, k == 3, TYPE_T0);
      mid();
      chk("p4_in_ready", 64'(in_ready), 64'd1);
      chk("p4_otv", 64'(otv), 64'(k == 0));
      if (k == 0) chk("p4_otd", 64'(otd), 64'(TYPE_T0));
      if (k > 0) begin
        chk("p4_tvalid", 64'(tvalid), 64'd1);
        chk("p4_tdata", tdata, pat(16*(k-1)));
        chk("p4_tkeep", 64'(tkeep), 64'hFF);
        chk("p4_tlast", 64'(tlast), 64'd0);
      end
    end
    tick(); idle(); mid();
    chk("p4_last_tvalid", 64'(tvalid), 64'd1);
    chk("p4_last_tdata", tdata, pat(48));
    chk("p4_last_tlast", 64'(tlast), 64'd1);
    tick(); mid();
    chk("p4_drain", 64'(tvalid), 64'd0);

    // Type sink stalled for 3 cycles at packet start
    tick();
    otr = 1'b0;
    drive(1'b1, 'h40, 8'hFF, 1'b0, TYPE_T2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      mid();
      chk("ts_in_ready", 64'(in_ready), 64'd0);
      chk("ts_otv", 64'(otv), 64'd1);
      chk("ts_otd", 64'(otd), 64'(TYPE_T2));
      chk("ts_tvalid", 64'(tvalid), 64'd0);
    end
    tick(); otr = 1'b1; mid();
    chk("ts_release_ready", 64'(in_ready), 64'd1);
    chk("ts_release_tvalid", 64'(tvalid), 64'd0);
    tick(); drive(1'b1, 'h50, 8'hFF, 1'b1, TYPE_T2); mid();
    chk("ts_body_otv", 64'(otv), 64'd0);
    chk("ts_b0_tvalid", 64'(tvalid), 64'd1);
    chk("ts_b0_tdata", tdata, pat('h40));
    chk("ts_b0_tlast", 64'(tlast), 64'd0);
    tick(); idle(); mid();
    chk("ts_b1_tdata", tdata, pat('h50));
    chk("ts_b1_tlast", 64'(tlast), 64'd1);
    tick(); mid();
    chk("ts_drain", 64'(tvalid), 64'd0);

    // tready toggling 1010..., 8-beat packet with data[I]=I+beat
    b = 0; recv = 0; nth = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (recv < 8 && cyc < 60) begin
      tick();
      tready = (cyc % 2 == 0);
      if (b < 8) drive(1'b1, b, 8'hFF, b == 7, TYPE_T3);
      else idle();
      mid();
      if (stalled) chk("tg_hold", tdata, held);
      if (tvalid && tready) begin
        chk("tg_tdata", tdata, pat(recv));
        chk("tg_tlast", 64'(tlast), 64'(recv == 7));
        recv++;
      end
      stalled = tvalid && !tready;
      held = tdata;
      if (otv && otr) nth++;
      if (in_valid && in_ready) b++;
      cyc++;
    end
    chk("tg_beats", 64'(recv), 64'd8);
    chk("tg_type_hs", 64'(nth), 64'd1);
    tick(); idle(); tready = 1'b1; mid();
    chk("tg_drain", 64'(tvalid), 64'd0);

    // Back-to-back single-beat packets T0,T1,T2 (middle one keep all-zero)
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      drive(1'b1, 'h80 + 8*k, (k == 1) ? 8'h00 : 8'hFF, 1'b1, ty[k]);
      mid();
      chk("sb_otv", 64'(otv), 64'd1);
      chk("sb_otd", 64'(otd), 64'(ty[k]));
      chk("sb_in_ready", 64'(in_ready), 64'd1);
      if (k > 0) begin
        chk("sb_tvalid", 64'(tvalid), 64'd1);
        chk("sb_tdata", tdata, pat('h80 + 8*(k-1)));
        chk("sb_tkeep", 64'(tkeep), (k == 2) ? 64'h00 : 64'hFF);
        chk("sb_tlast", 64'(tlast), 64'd1);
      end
    end
    tick(); idle(); mid();
    chk("sb_last_tdata", tdata, pat('h90));
    chk("sb_last_tkeep", 64'(tkeep), 64'hFF);
    chk("sb_last_tlast", 64'(tlast), 64'd1);
    tick(); mid();
    chk("sb_drain", 64'(tvalid), 64'd0);

    // Reset mid-packet: next beat is a new packet start
    tick(); drive(1'b1, 'hA0, 8'hFF, 1'b0, TYPE_T1); mid();
    chk("mr_otv0", 64'(otv), 64'd1);
    tick(); drive(1'b1, 'hA8, 8'hFF, 1'b0, TYPE_T1); mid();
    chk("mr_otv1", 64'(otv), 64'd0);
    tick(); rst_n = 1'b0; mid();
    tick(); rst_n = 1'b1; drive(1'b1, 'hB0, 8'hFF, 1'b1, TYPE_T3); mid();
    chk("mr_tvalid", 64'(tvalid), 64'd0);
    chk("mr_otv", 64'(otv), 64'd1);
    chk("mr_otd", 64'(otd), 64'(TYPE_T3));
    tick(); idle(); mid();
    chk("mr_out_tdata", tdata, pat('hB0));
    chk("mr_out_tlast", 64'(tlast), 64'd1);
    tick(); mid();

`ifdef TYPED_NDATA_TO_AXI_TYPE_CHECK_EN
    // Beat 2 carries T1 against latched T0
    tick(); drive(1'b1, 'hC0, 8'hFF, 1'b0, TYPE_T0); mid();
    chk("tc_b0_err", 64'(type_err), 64'd0);
    tick(); drive(1'b1, 'hC8, 8'hFF, 1'b0, TYPE_T0); mid();
    chk("tc_b1_err", 64'(type_err), 64'd0);
    tick(); drive(1'b1, 'hD0, 8'hFF, 1'b0, TYPE_T1); mid();
    chk("tc_b2_err", 64'(type_err), 64'd0);
    tick(); drive(1'b1, 'hD8, 8'hFF, 1'b1, TYPE_T0); mid();
    chk("tc_err_set", 64'(type_err), 64'd1);
    chk("tc_fwd_tdata", tdata, pat('hD0));
    tick(); idle(); mid();
    chk("tc_err_sticky", 64'(type_err), 64'd1);
    tick(); mid();
    chk("tc_err_sticky2", 64'(type_err), 64'd1);
    tick(); rst_n = 1'b0; mid();
    tick(); rst_n = 1'b1; drive(1'b1, 'hE0, 8'hFF, 1'b1, TYPE_T2); mid();
    chk("tc_err_cleared", 64'(type_err), 64'd0);
    chk("tc_otv", 64'(otv), 64'd1);
    chk("tc_otd", 64'(otd), 64'(TYPE_T2));
    tick(); idle(); mid();
    chk("tc_err_after", 64'(type_err), 64'd0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/typed_ndata_to_axi.md
Name: typed_ndata_to_axi

Overview:
- Inverse of the AXI-to-typed-ndata path: accepts a typed ndata stream of data8_t bytes with a per-beat type tag.
- Emits the bytes as a DATABEAT_SIZE*8-bit AXI stream and the type as a separate ready_valid stream.
- The type is emitted exactly once per packet, at packet start.
- Sits at the egress of typed operator pipelines, before DMA or network writers that consume untyped AXI plus a per-packet type descriptor.

Parameters:
- DATABEAT_SIZE, 64, number of data8_t elements per beat.
- AXI_WIDTH, DATABEAT_SIZE*8, AXI tdata width; tkeep width is AXI_WIDTH/8 = DATABEAT_SIZE.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- in  typed_ndata_i.s  #(DATABEAT_SIZE)  data[DATABEAT_SIZE], keep[DATABEAT_SIZE], last, valid, typ (type_t); ready driven by block.
- out_type  ready_valid_i.m  #(type_t)  per-packet type descriptor.
- out  AXI4S.m  #(AXI_WIDTH)  tdata, tkeep, tlast, tvalid; tready from sink.
- type_err  output  1  sticky mismatch flag; present only with the optional feature.

Behaviour:
- State flag type_sent: 0 = FIRST (type of current packet not yet emitted), 1 = BODY. Reset: type_sent=0.
- out_type.valid = in.valid && !type_sent; out_type.data = in.typ (combinational, from the first beat).
- Output register: one stage holding tdata/tkeep/tlast/tvalid. can_load = !out.tvalid || out.tready.
- in.ready = can_load && (type_sent || out_type.ready).
  - The first beat of a packet never passes before, or without, its type handshake.
  - Type and first beat may transfer in the same cycle.
- Beat accept (in.valid && in.ready): load register.
  - tdata[8*I+:8] = data[I].
  - tkeep[I] = keep[I].
  - tlast = last.
  - tvalid = 1.
- If can_load && no accept: tvalid <= 0. If !can_load: hold all fields (AXI stability; data must not change while tvalid && !tready).
- Latency: 1 cycle from in accept to out.tvalid. Throughput: 1 beat/cycle when tready and out_type.ready stay high.
- Transitions:
  - FIRST -> BODY on out_type handshake when the same-cycle accepted beat is not last.
  - Single-beat packet (accept with last=1 while type handshakes): remain FIRST.
  - BODY -> FIRST on accept of a beat with last=1.
  - Type handshake without beat accept (output stalled): type_sent <= 1. The held beat then transfers later in BODY.
    - If that beat has last=1, return to FIRST on its accept.
- Latched type: captured on each out_type handshake; used by the optional check.
- keep all-zero beats are forwarded unchanged; no filtering.
- Reset mid-packet: type_sent=0, tvalid=0; next beat is treated as a new packet start, and its type is re-emitted.
- Reset values: out.tvalid=0, out_type.valid=0 (follows in.valid && !type_sent, so 0 while in.valid=0), type_err=0. tdata/tkeep/tlast are don't-care.

Optional Feature:
- Macro TYPED_NDATA_TO_AXI_TYPE_CHECK_EN.
- Defined: on every beat accepted in BODY, compare in.typ with the latched type. On mismatch, set type_err <= 1 (sticky until reset); data still forwards unchanged.
- Undefined: no type_err port, no comparator, no latched-type register. in.typ is ignored after the first beat of each packet.

Decomposition:
- Use type_t from package libstf; no new package types needed.
- Add localparam-free helper only if needed; keep AXI_WIDTH derived in module.
- Sub-module axis_output_reg #(AXI_WIDTH): single-stage ready-chained AXI register (load/hold/clear). It is reusable by the other ndata-to-AXI adapters.

Test Plan:
- Reset, then in.valid=0 for 5 cycles -> out.tvalid=0, out_type.valid=0.
- 4-beat packet, typ=T0, all sinks ready -> one out_type handshake (data=T0) in the cycle of beat 0.
  - out beats 1 cycle later, tkeep=all ones, tlast on beat 3 only.
  - Next packet re-emits type.
- out_type.ready=0 for 3 cycles at packet start -> in.ready=0 and no out.tvalid until out_type.ready rises; beat 0 then appears on out the following cycle.
- out.tready toggled 1010..., 8-beat packet with byte pattern data[I]=I+beat -> tdata/tkeep held stable while stalled; all 8 beats in order; exactly one type handshake.
- Back-to-back single-beat packets (last=1 every beat), types T0,T1,T2 -> three type handshakes with T0,T1,T2 in order; three out beats each tlast=1.
- With TYPED_NDATA_TO_AXI_TYPE_CHECK_EN: beat 2 of a packet carries typ=T1 against latched T0 -> type_err=1 from the next cycle and stays 1; data forwarded. Reset mid-packet -> type_err=0, and the next beat emits its type.
